// File: rtl/axi_lite_regs.sv
// AXI4-Lite slave register bank: NUM_REGS words, RW or hardware-driven RO.
// Ports: AXI-Lite aw/w/b/ar/r channels, reg_d_i (RO values), reg_q_o, reg_wr_o.
module axi_lite_regs #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AW-1:0]          aw_addr_i,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [DW-1:0]          w_data_i,
  input  logic [DW/8-1:0]        w_strb_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  output logic [1:0]             b_resp_o,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  input  logic [AW-1:0]          ar_addr_i,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  output logic [DW-1:0]          r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  input  logic [NUM_REGS*DW-1:0] reg_d_i,
  output logic [NUM_REGS*DW-1:0] reg_q_o,
  output logic [NUM_REGS-1:0]    reg_wr_o
);

  localparam int BW = DW / 8;
  localparam int OFF = $clog2(BW);
  localparam int IW = AW - OFF;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic              aw_full;
  logic              w_full;
  logic [IW-1:0]     aw_idx;
  logic [DW-1:0]     w_data;
  logic [BW-1:0]     w_strb;
  logic [DW-1:0]     regs [NUM_REGS];
  logic [IW-1:0]     ar_idx;
  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  logic [NUM_REGS-1:0] wr_hit;
  logic              wr_ok;
  logic [DW-1:0]     rd_data;
  logic              rd_ok;
  logic              unused_addr;

  assign unused_addr = ^{aw_addr_i[OFF-1:0], ar_addr_i[OFF-1:0]};

  assign aw_ready_o = !rst_i && !aw_full && !b_valid_o;
  assign w_ready_o  = !rst_i && !w_full && !b_valid_o;
  assign ar_ready_o = !rst_i && !r_valid_o;

  assign aw_hs  = aw_valid_i && aw_ready_o;
  assign w_hs   = w_valid_i && w_ready_o;
  assign ar_hs  = ar_valid_i && ar_ready_o;
  assign commit = aw_full && w_full;
  assign ar_idx = ar_addr_i[AW-1:OFF];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign reg_q_o[g*DW +: DW] =
      RO_MASK[g] ? reg_d_i[g*DW +: DW] : regs[g];
  end

  // Out-of-range indices match no slot, so they fall out as SLVERR.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit[i] = (aw_idx == IW'(i)) && !RO_MASK[i];
    end
    wr_ok = |wr_hit;
  end

  always_comb begin
    rd_data = '0;
    rd_ok = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IW'(i)) begin
        rd_data = reg_q_o[i*DW +: DW];
        rd_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_idx    <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      b_valid_o <= 1'b0;
      b_resp_o  <= OKAY;
      r_valid_o <= 1'b0;
      r_resp_o  <= OKAY;
      r_data_o  <= '0;
      reg_wr_o  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      reg_wr_o <= '0;
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= aw_addr_i[AW-1:OFF];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= w_data_i;
        w_strb <= w_strb_i;
      end
      if (commit) begin
        aw_full   <= 1'b0;
        w_full    <= 1'b0;
        b_valid_o <= 1'b1;
        b_resp_o  <= wr_ok ? OKAY : SLVERR;
        reg_wr_o  <= wr_hit;
        for (int i = 0; i < NUM_REGS; i++) begin
          for (int k = 0; k < BW; k++) begin
            if (wr_hit[i] && w_strb[k]) begin
              regs[i][k*8 +: 8] <= w_data[k*8 +: 8];
            end
          end
        end
      end else if (b_valid_o && b_ready_i) begin
        b_valid_o <= 1'b0;
      end
      if (ar_hs) begin
        r_valid_o <= 1'b1;
        r_data_o  <= rd_data;
        r_resp_o  <= rd_ok ? OKAY : SLVERR;
      end else if (r_valid_o && r_ready_i) begin
        r_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_regs.sv
// Self-checking bench for axi_lite_regs with RO_MASK=0x01.
// Directed steps plus randomized traffic against a word-array model.
module tb_axi_lite_regs;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  aw_addr;
  logic         aw_valid;
  logic         aw_ready;
  logic [31:0]  w_data;
  logic [3:0]   w_strb;
  logic         w_valid;
  logic         w_ready;
  logic [1:0]   b_resp;
  logic         b_valid;
  logic         b_ready;
  logic [31:0]  ar_addr;
  logic         ar_valid;
  logic         ar_ready;
  logic [31:0]  r_data;
  logic [1:0]   r_resp;
  logic         r_valid;
  logic         r_ready;
  logic [255:0] reg_d;
  logic [255:0] reg_q;
  logic [7:0]   reg_wr;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m [8];

  always #5 clk = ~clk;

  axi_lite_regs #(
    .AW(32), .DW(32), .NUM_REGS(8), .RO_MASK(8'h01)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid),
    .w_ready_o(w_ready),
    .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .ar_addr_i(ar_addr), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid),
    .r_ready_i(r_ready),
    .reg_d_i(reg_d), .reg_q_o(reg_q), .reg_wr_o(reg_wr)
  );

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] expq();
    logic [255:0] v;
    for (int i = 0; i < 8; i++)
      v[i*32 +: 32] = (i == 0) ? reg_d[31:0] : m[i];
    return v;
  endfunction

  task automatic new_reg_d();
    for (int i = 0; i < 8; i++) reg_d[i*32 +: 32] = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input int ad, input int wd,
                    input int bdly, input bit ack);
    int c = 0;
    bit a_done = 0;
    bit w_done = 0;
    bit ha, hw, ok;
    int idx;
    logic [7:0] ewr;
    logic [1:0] eresp;
    aw_addr = addr;
    w_data = data;
    w_strb = strb;
    while (!(a_done && w_done) && c < 20) begin
      aw_valid = !a_done && c >= ad;
      w_valid = !w_done && c >= wd;
      ha = aw_valid && aw_ready;
      hw = w_valid && w_ready;
      tick();
      if (ha) a_done = 1;
      if (hw) w_done = 1;
      c++;
    end
    aw_valid = 0;
    w_valid = 0;
    chk("wr_handshake", {a_done, w_done}, 2'b11);
    chk("b_early", b_valid, 1'b0);
    chk("wr_early", reg_wr, 8'h00);
    tick();
    idx = int'(addr >> 2);
    ok = (idx < 8) && (idx != 0);
    ewr = 8'h00;
    if (ok) begin
      for (int k = 0; k < 4; k++)
        if (strb[k]) m[idx][k*8 +: 8] = data[k*8 +: 8];
      ewr = 8'(1 << idx);
    end
    eresp = ok ? 2'b00 : 2'b10;
    chk("b_valid", b_valid, 1'b1);
    chk("b_resp", b_resp, eresp);
    chk("reg_wr", reg_wr, ewr);
    chk("reg_q", reg_q, expq());
    if (!ack) return;
    for (int i = 0; i < bdly; i++) begin
      tick();
      chk("b_hold", {b_valid, b_resp}, {1'b1, eresp});
      chk("wr_pulse", reg_wr, 8'h00);
      chk("aw_blocked", aw_ready, 1'b0);
    end
    b_ready = 1;
    tick();
    b_ready = 0;
    chk("b_clear", b_valid, 1'b0);
    chk("ready_back", {aw_ready, w_ready}, 2'b11);
  endtask

  task automatic rd(input logic [31:0] addr, input int rdly);
    int c = 0;
    int idx;
    logic [31:0] ed;
    logic [1:0] er;
    ar_addr = addr;
    ar_valid = 1;
    while (!ar_ready && c < 10) begin
      tick();
      c++;
    end
    chk("ar_ready", ar_ready, 1'b1);
    idx = int'(addr >> 2);
    if (idx >= 8) begin
      ed = 32'h0;
      er = 2'b10;
    end else begin
      ed = (idx == 0) ? reg_d[31:0] : m[idx];
      er = 2'b00;
    end
    tick();
    ar_valid = 0;
    new_reg_d();
    chk("r_valid", r_valid, 1'b1);
    chk("r_data", r_data, ed);
    chk("r_resp", r_resp, er);
    for (int i = 0; i < rdly; i++) begin
      tick();
      chk("r_hold", {r_valid, r_resp, r_data}, {1'b1, er, ed});
      chk("ar_blocked", ar_ready, 1'b0);
    end
    r_ready = 1;
    tick();
    r_ready = 0;
    chk("r_clear", r_valid, 1'b0);
  endtask

  initial begin
    rst = 1;
    aw_addr = 0; aw_valid = 0; w_data = 0; w_strb = 0; w_valid = 0;
    b_ready = 0; ar_addr = 0; ar_valid = 0; r_ready = 0;
    reg_d = '0;
    for (int i = 0; i < 8; i++) m[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_readies", {aw_ready, w_ready, ar_ready}, 3'b000);
    rst = 0;
    #1;
    chk("post_rst_readies", {aw_ready, w_ready, ar_ready}, 3'b111);
    chk("post_rst_valid", {b_valid, r_valid}, 2'b00);
    chk("post_rst_q", reg_q, expq());

    wr(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 1, 1);
    chk("slot1", reg_q[63:32], 32'hDEADBEEF);
    wr(32'h8, 32'hAAAAAAAA, 4'hF, 0, 0, 0, 1);
    wr(32'h8, 32'h11223344, 4'h5, 3, 0, 0, 1);
    chk("slot2_merge", reg_q[95:64], 32'hAA22AA44);
    rd(32'h4, 3);
    wr(32'h20, 32'h12345678, 4'hF, 0, 1, 0, 1);
    rd(32'h20, 1);
    reg_d[31:0] = 32'hCAFEF00D;
    wr(32'h0, 32'h55555555, 4'hF, 1, 0, 0, 1);
    chk("ro_slot0", reg_q[31:0], 32'hCAFEF00D);
    reg_d[31:0] = 32'hCAFEF00D;
    rd(32'h0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      new_reg_d();
      a = {26'd0, 4'($urandom_range(0, 9)), 2'($urandom)};
      if ($urandom_range(0, 1) == 1)
        wr(a, $urandom, 4'($urandom), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 2), 1);
      else
        rd(a, $urandom_range(0, 2));
    end

    wr(32'h4, 32'h0BADF00D, 4'hF, 0, 0, 0, 0);
    rst = 1;
    tick();
    for (int i = 0; i < 8; i++) m[i] = 32'h0;
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_hold_readies", {aw_ready, w_ready, ar_ready}, 3'b000);
    chk("rst_q", reg_q, expq());
    chk("rst_wr", reg_wr, 8'h00);
    rst = 0;
    #1;
    chk("rst_release", {aw_ready, w_ready, ar_ready}, 3'b111);
    wr(32'hC, 32'h600DCAFE, 4'hC, 0, 2, 0, 1);
    rd(32'hC, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
